// File: rtl/risc_controller.sv
// Instruction-sequencing controller for the 8-bit accumulator CPU.
// Steps the 8-phase fetch/execute cycle and decodes every datapath strobe from phase, opcode and zero.
module risc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       resume,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_t state;
    phase_t state_next;
    logic   halted;
    logic   halted_next;
    logic   alu_op;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
        end
    end

    // A halt parks the counter on OP_ADDR; only resume (or reset) moves it again.
    always_comb begin
        state_next  = state;
        halted_next = halted;
        if (halted) begin
            if (resume) begin
                state_next  = INST_ADDR;
                halted_next = 1'b0;
            end
        end else if (state == OP_ADDR && opcode == OP_HLT) begin
            halted_next = 1'b1;
        end else begin
            state_next = phase_t'(state + 3'd1);
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        phase  = state;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (state)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: begin
                    rd = alu_op;
                end
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_controller.sv
// Directed self-checking bench for risc_controller.
// Strobe vectors are ordered {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}.
module tb_risc_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;
    logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
    logic [2:0] phase;

    int testsRun;
    int testsFailed;

    localparam logic [8:0] P0     = 9'b100000000;
    localparam logic [8:0] P1     = 9'b110000000;
    localparam logic [8:0] P23    = 9'b110100000;
    localparam logic [8:0] P4     = 9'b000010000;
    localparam logic [8:0] P4_HLT = 9'b000010001;
    localparam logic [8:0] HALTED = 9'b000000001;
    localparam logic [8:0] NONE   = 9'b000000000;
    localparam logic [8:0] RD     = 9'b010000000;
    localparam logic [8:0] RD_LDA = 9'b010000100;
    localparam logic [8:0] DATA_E = 9'b000000010;
    localparam logic [8:0] WR_DE  = 9'b001000010;
    localparam logic [8:0] INCPC  = 9'b000010000;
    localparam logic [8:0] LDPC   = 9'b000001000;

    risc_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .resume (resume),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] expStrobes, input logic [2:0] expPhase);
        logic [11:0] observed;
        logic [11:0] expected;
        observed = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase};
        expected = {expStrobes, expPhase};
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic runFetch(input string tag);
        checkOutput({tag, " p0"}, P0, 3'd0);
        applyStimulus();
        checkOutput({tag, " p1"}, P1, 3'd1);
        applyStimulus();
        checkOutput({tag, " p2"}, P23, 3'd2);
        applyStimulus();
        checkOutput({tag, " p3"}, P23, 3'd3);
        applyStimulus();
    endtask

    task automatic runInstr(input string tag, input logic [2:0] op, input logic z,
                            input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7);
        opcode = op;
        zero   = z;
        runFetch(tag);
        checkOutput({tag, " p4"}, P4, 3'd4);
        applyStimulus();
        checkOutput({tag, " p5"}, e5, 3'd5);
        applyStimulus();
        checkOutput({tag, " p6"}, e6, 3'd6);
        applyStimulus();
        checkOutput({tag, " p7"}, e7, 3'd7);
        applyStimulus();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst    = 1'b0;
        opcode = 3'b101;
        zero   = 1'b0;
        resume = 1'b0;

        applyStimulus();
        checkOutput("reset held 1", P0, 3'd0);
        applyStimulus();
        checkOutput("reset held 2", P0, 3'd0);
        rst = 1'b1;

        runInstr("LDA", 3'b101, 1'b0, RD, RD, RD_LDA);
        runInstr("STO", 3'b110, 1'b0, NONE, DATA_E, WR_DE);
        runInstr("SKZ z1", 3'b001, 1'b1, NONE, INCPC, NONE);
        runInstr("SKZ z0", 3'b001, 1'b0, NONE, NONE, NONE);
        runInstr("JMP", 3'b111, 1'b0, NONE, LDPC, LDPC);
        resume = 1'b1;
        runInstr("ADD resume ignored", 3'b010, 1'b1, RD, RD, RD_LDA);
        resume = 1'b0;
        runInstr("XOR", 3'b100, 1'b0, RD, RD, RD_LDA);
        runInstr("AND", 3'b011, 1'b0, RD, RD, RD_LDA);

        // Halt, sit for 20 cycles, then resume into the next fetch.
        opcode = 3'b000;
        runFetch("HLT");
        checkOutput("HLT p4", P4_HLT, 3'd4);
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            checkOutput("HLT parked", HALTED, 3'd4);
        end
        resume = 1'b1;
        applyStimulus();
        resume = 1'b0;
        checkOutput("HLT resumed", P0, 3'd0);
        runInstr("LDA after resume", 3'b101, 1'b0, RD, RD, RD_LDA);

        // Reset during phase 6 of a jump.
        opcode = 3'b111;
        runFetch("JMP rst");
        checkOutput("JMP rst p4", P4, 3'd4);
        applyStimulus();
        checkOutput("JMP rst p5", NONE, 3'd5);
        applyStimulus();
        checkOutput("JMP rst p6", LDPC, 3'd6);
        rst = 1'b0;
        applyStimulus();
        checkOutput("JMP rst applied", P0, 3'd0);
        rst = 1'b1;
        runInstr("STO after rst", 3'b110, 1'b0, NONE, DATA_E, WR_DE);

        // Reset coinciding with resume while halted.
        opcode = 3'b000;
        runFetch("HLT2");
        checkOutput("HLT2 p4", P4_HLT, 3'd4);
        applyStimulus();
        checkOutput("HLT2 parked", HALTED, 3'd4);
        rst    = 1'b0;
        resume = 1'b1;
        applyStimulus();
        checkOutput("HLT2 rst+resume", P0, 3'd0);
        rst    = 1'b1;
        resume = 1'b0;
        applyStimulus();
        checkOutput("HLT2 restart p1", P1, 3'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
